// File: rtl/hazard_controller.sv
// Hazard and sequencing controller for the 5-stage RV32 pipeline: forwarding, load-use
// and branch hazards, a data-memory wait FSM with timeout halt, and stall/flush counters.
module hazard_controller #(
  parameter int WAIT_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  Rs1E,
  input  logic [4:0]  Rs2E,
  input  logic [4:0]  RdE,
  input  logic [1:0]  ResultSrcE,
  input  logic        PCSrcE,
  input  logic [4:0]  RdM,
  input  logic        RegWriteM,
  input  logic [4:0]  RdW,
  input  logic        RegWriteW,
  input  logic        MemReqM,
  input  logic        MemReadyM,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        StallM,
  output logic        FlushD,
  output logic        FlushE,
  output logic        FlushW,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        MemErr,
  output logic [31:0] StallCount,
  output logic [31:0] FlushCount
);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_WAIT = 2'd1,
    S_HALT = 2'd2
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(WAIT_TIMEOUT - 1);

  state_t      state;
  logic [7:0]  wait_cnt;
  logic        mem_err_q;
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  logic lw_stall;
  logic mem_wait;
  logic branch_flush;

  assign lw_stall = (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
                    ((RdE == Rs1D) || (RdE == Rs2D));
  assign mem_wait = MemReqM && !MemReadyM;

  assign MemErr     = mem_err_q;
  assign StallCount = stall_cnt_q;
  assign FlushCount = flush_cnt_q;

  // Memory-stage result is younger than Writeback, so it wins when both match.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic [4:0] rd_m, input logic we_m,
                                         input logic [4:0] rd_w, input logic we_w);
    if (we_m && (rd_m != 5'd0) && (rd_m == rs))      return 2'b10;
    else if (we_w && (rd_w != 5'd0) && (rd_w == rs)) return 2'b01;
    else                                              return 2'b00;
  endfunction

  always_comb begin
    // NOTE: every output gets a default first so no path through the priority chain infers a latch.
    StallF       = 1'b0;
    StallD       = 1'b0;
    StallE       = 1'b0;
    StallM       = 1'b0;
    FlushD       = 1'b0;
    FlushE       = 1'b0;
    FlushW       = 1'b0;
    branch_flush = 1'b0;
    ForwardAE    = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
    ForwardBE    = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
    if (rst) begin
      FlushD    = 1'b1;
      FlushE    = 1'b1;
      FlushW    = 1'b1;
      ForwardAE = 2'b00;
      ForwardBE = 2'b00;
    end else if (state == S_HALT || mem_wait) begin
      // Whole pipe frozen; branch and load-use are re-judged once Execute moves again.
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else if (PCSrcE) begin
      FlushD       = 1'b1;
      FlushE       = 1'b1;
      branch_flush = 1'b1;
    end else if (lw_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_RUN;
      wait_cnt    <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (StallF && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (branch_flush && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 32'd1;
      case (state)
        S_RUN: begin
          if (mem_wait) begin
            state    <= S_WAIT;
            wait_cnt <= '0;
          end
        end
        S_WAIT: begin
          if (MemReadyM) begin
            state <= S_RUN;
          end else if (mem_wait && (wait_cnt == WAIT_LAST)) begin
            state     <= S_HALT;
            mem_err_q <= 1'b1;
          end else if (wait_cnt != '1) begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: directed scenarios with literal expectations
// plus randomized cycles compared every cycle against a behavioural model.
module tb_hazard_controller;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0]  ResultSrcE;
  logic        PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM;
  logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [31:0] StallCount, FlushCount;

  int passed = 0;
  int total  = 0;

  // Model state: abstract flags and plain counters.
  bit          m_halted, m_waiting, m_err;
  int          m_waited;
  logic [31:0] m_sc, m_fc;
  // Model expectations for the current cycle.
  bit          e_sf, e_sd, e_se, e_sm, e_fd, e_fe, e_fw, e_branch;
  logic [1:0]  e_fa, e_fb;

  always #5 clk = ~clk;

  hazard_controller #(.WAIT_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
    .RdM(RdM), .RegWriteM(RegWriteM), .RdW(RdW), .RegWriteW(RegWriteW),
    .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .MemErr(MemErr), .StallCount(StallCount), .FlushCount(FlushCount)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic idle();
    rst = 1'b0; Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    ResultSrcE = 2'b00; PCSrcE = 0; RegWriteM = 0; RegWriteW = 0; MemReqM = 0; MemReadyM = 0;
  endtask

  function automatic logic [1:0] model_fwd(input logic [4:0] rs);
    if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
    if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_comb();
    bit lw, mw;
    lw = (ResultSrcE == 2'b01) && (RdE != 0) && (RdE == Rs1D || RdE == Rs2D);
    mw = MemReqM && !MemReadyM;
    {e_sf, e_sd, e_se, e_sm, e_fd, e_fe, e_fw, e_branch} = '0;
    e_fa = rst ? 2'b00 : model_fwd(Rs1E);
    e_fb = rst ? 2'b00 : model_fwd(Rs2E);
    if (rst) begin
      e_fd = 1; e_fe = 1; e_fw = 1;
    end else if (m_halted || mw) begin
      e_sf = 1; e_sd = 1; e_se = 1; e_sm = 1; e_fw = 1;
    end else if (PCSrcE) begin
      e_fd = 1; e_fe = 1; e_branch = 1;
    end else if (lw) begin
      e_sf = 1; e_sd = 1; e_fe = 1;
    end
  endtask

  task automatic model_edge();
    bit mw;
    mw = MemReqM && !MemReadyM;
    if (rst) begin
      m_halted = 0; m_waiting = 0; m_waited = 0; m_err = 0; m_sc = 0; m_fc = 0;
    end else begin
      if (e_sf && m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
      if (e_branch && m_fc != 32'hFFFF_FFFF) m_fc = m_fc + 1;
      if (!m_halted) begin
        if (!m_waiting) begin
          if (mw) begin m_waiting = 1; m_waited = 0; end
        end else if (MemReadyM) begin
          m_waiting = 0;
        end else if (mw && m_waited == TO - 1) begin
          m_halted = 1; m_err = 1;
        end else if (m_waited < 255) begin
          m_waited++;
        end
      end
    end
  endtask

  // Settle combinational outputs and compare everything against the model.
  task automatic settle();
    #1;
    model_comb();
    check("StallF", StallF, e_sf);
    check("StallD", StallD, e_sd);
    check("StallE", StallE, e_se);
    check("StallM", StallM, e_sm);
    check("FlushD", FlushD, e_fd);
    check("FlushE", FlushE, e_fe);
    check("FlushW", FlushW, e_fw);
    check("ForwardAE", ForwardAE, e_fa);
    check("ForwardBE", ForwardBE, e_fb);
    check("MemErr", MemErr, m_err);
    check("StallCount", StallCount, m_sc);
    check("FlushCount", FlushCount, m_fc);
  endtask

  task automatic advance();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle(); rst = 1'b1;
    settle(); advance();
    rst = 1'b0;
  endtask

  function automatic logic [4:0] pick_reg();
    case ($urandom % 5)
      0: return 5'd0;
      1: return 5'd5;
      2: return 5'd7;
      3: return 5'd31;
      default: return 5'($urandom);
    endcase
  endfunction

  initial begin
    idle();
    m_halted = 0; m_waiting = 0; m_waited = 0; m_err = 0; m_sc = 0; m_fc = 0;
    @(negedge clk);
    do_reset();

    // Reset state
    settle();
    check("rst_StallCount", StallCount, 32'd0);
    check("rst_FlushCount", FlushCount, 32'd0);
    check("rst_MemErr", MemErr, 32'd0);

    // Load-use bubble
    ResultSrcE = 2'b01; RdE = 5; Rs1D = 5;
    settle();
    check("lu_StallF", StallF, 1); check("lu_StallD", StallD, 1); check("lu_FlushE", FlushE, 1);
    advance();
    idle(); RdM = 5; RegWriteM = 1; Rs1E = 5;
    settle();
    check("lu_fwdA", ForwardAE, 2'b10);
    check("lu_StallCount", StallCount, 32'd1);
    check("lu_no_stall", StallF, 0);
    advance();

    // Forward priority and x0
    idle(); RdM = 7; RdW = 7; Rs2E = 7; RegWriteM = 1; RegWriteW = 1;
    settle();
    check("fwd_prio_B", ForwardBE, 2'b10);
    advance();
    idle(); RdW = 7; Rs2E = 7; RegWriteW = 1; RegWriteM = 1; RdM = 0; Rs1E = 0;
    settle();
    check("fwd_wb_B", ForwardBE, 2'b01);
    check("fwd_x0_A", ForwardAE, 2'b00);
    advance();

    // Taken branch
    idle(); PCSrcE = 1;
    settle();
    check("br_FlushD", FlushD, 1); check("br_FlushE", FlushE, 1); check("br_StallF", StallF, 0);
    advance();
    idle();
    settle();
    check("br_FlushCount", FlushCount, 32'd1);
    advance();

    // Memory wait of 3 cycles, branch ignored while held
    do_reset();
    for (int i = 0; i < 3; i++) begin
      idle(); MemReqM = 1; PCSrcE = 1;
      settle();
      check("mw_StallM", StallM, 1); check("mw_FlushW", FlushW, 1); check("mw_no_FlushD", FlushD, 0);
      advance();
    end
    idle(); MemReqM = 1; MemReadyM = 1;
    settle();
    check("mw_release", StallF, 0);
    advance();
    idle();
    settle();
    check("mw_StallCount", StallCount, 32'd3);
    check("mw_FlushCount", FlushCount, 32'd0);
    advance();

    // Timeout halt
    do_reset();
    for (int i = 0; i < TO + 1; i++) begin
      idle(); MemReqM = 1;
      settle();
      check("to_err_pending", MemErr, 0);
      advance();
    end
    idle(); MemReqM = 1;
    settle();
    check("to_MemErr", MemErr, 1);
    advance();
    idle(); MemReqM = 1; MemReadyM = 1;
    settle();
    check("to_halt_StallF", StallF, 1);
    check("to_halt_StallM", StallM, 1);
    advance();
    do_reset();
    settle();
    check("to_rst_MemErr", MemErr, 0);
    check("to_rst_StallCount", StallCount, 32'd0);
    check("to_rst_StallF", StallF, 0);
    advance();

    // Reset priority over load-use and memory wait
    idle(); rst = 1; ResultSrcE = 2'b01; RdE = 5; Rs1D = 5; MemReqM = 1;
    settle();
    check("rp_StallF", StallF, 0); check("rp_StallM", StallM, 0);
    check("rp_FlushD", FlushD, 1); check("rp_FlushW", FlushW, 1);
    advance();
    idle();

    // Stall counter saturation
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt_q;
    m_sc = 32'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) begin
      idle(); ResultSrcE = 2'b01; RdE = 5; Rs1D = 5;
      settle();
      advance();
    end
    idle();
    settle();
    check("sat_StallCount", StallCount, 32'hFFFF_FFFF);
    advance();

    // Randomized cycles against the model
    do_reset();
    for (int n = 0; n < 600; n++) begin
      rst        = ($urandom % 40) == 0;
      Rs1D       = pick_reg(); Rs2D = pick_reg();
      Rs1E       = pick_reg(); Rs2E = pick_reg();
      RdE        = pick_reg(); RdM  = pick_reg(); RdW = pick_reg();
      ResultSrcE = 2'($urandom);
      PCSrcE     = ($urandom % 6) == 0;
      RegWriteM  = 1'($urandom);
      RegWriteW  = 1'($urandom);
      MemReqM    = ($urandom % 3) == 0;
      MemReadyM  = ($urandom % 3) != 0;
      settle();
      advance();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/hazard_controller.md
# hazard_controller

Pipeline hazard and sequencing controller for the 5-stage RV32 core. Generates the Execute-stage clear (`FlushE` drives the ID/EX register's `CLR_E`), the fetch/decode/execute/memory stall enables, the Decode/Writeback flushes and the Execute-stage forwarding selects. It adds a registered data-memory wait FSM with timeout, a sticky error halt, and saturating stall/flush performance counters. It sits beside the datapath and is driven by stage register fields and the data-memory handshake.

## Interface

**Parameters**
- `WAIT_TIMEOUT`, default 16: maximum consecutive memory-wait cycles before halt. Legal range 2..255.

**Ports**
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `Rs1D`, `Rs2D` in 5: Decode source registers.
- `Rs1E`, `Rs2E`, `RdE` in 5: Execute source and destination registers.
- `ResultSrcE` in 2: `2'b01` means the instruction in Execute is a load.
- `PCSrcE` in 1: branch taken or jump in Execute.
- `RdM`, `RegWriteM` in 5/1: Memory-stage destination and write enable.
- `RdW`, `RegWriteW` in 5/1: Writeback-stage destination and write enable.
- `MemReqM` in 1: the instruction in Memory accesses data memory.
- `MemReadyM` in 1: data memory has completed the access this cycle.
- `StallF`, `StallD`, `StallE`, `StallM` out 1: hold the PC and the IF/ID, ID/EX and EX/MEM registers.
- `FlushD`, `FlushE`, `FlushW` out 1: clear the IF/ID, ID/EX and MEM/WB registers.
- `ForwardAE`, `ForwardBE` out 2: ALU operand select. `00` = register file, `10` = Memory-stage ALU result, `01` = Writeback result.
- `MemErr` out 1: sticky memory-timeout flag.
- `StallCount` out 32: cycles with `StallF=1`; saturates at 32'hFFFFFFFF.
- `FlushCount` out 32: cycles with a control flush (`PCSrcE` honoured); saturates.

## Operation

**Forwarding** (combinational, in every state)
- `ForwardAE = 10` if `RegWriteM & (RdM!=0) & (RdM==Rs1E)`.
- Otherwise `ForwardAE = 01` if `RegWriteW & (RdW!=0) & (RdW==Rs1E)`.
- Otherwise `ForwardAE = 00`. Memory-stage forwarding has priority.
- `ForwardBE` uses the same rules with `Rs2E`.

**Load-use hazard**
- `lwStall = (ResultSrcE==01) & (RdE!=0) & ((RdE==Rs1D)|(RdE==Rs2D))`.

**Memory wait**
- `memWait = MemReqM & ~MemReadyM`.

**FSM states: RUN, WAIT, HALT**
- RUN → WAIT when `memWait`. Stay in RUN otherwise.
- WAIT → RUN when `MemReadyM`.
- WAIT → HALT when `memWait` holds and the wait counter equals `WAIT_TIMEOUT-1`. On this transition, set `MemErr`.
- HALT is left only by `rst`.
- The wait counter is cleared on entry to WAIT and increments each WAIT cycle.

**Output priority** (highest first; all outputs not listed are 0)
1. `rst` = 1: `FlushD=FlushE=FlushW=1`, all stalls 0, forwards `00`.
2. State is HALT: `StallF=StallD=StallE=StallM=1`, `FlushW=1`.
3. `memWait` in RUN or WAIT: all four stalls 1, `FlushW=1`. `PCSrcE` and `lwStall` are ignored because Execute is held; they are re-evaluated after release.
4. `PCSrcE`: `FlushD=FlushE=1`, `StallF=0`.
5. `lwStall`: `StallF=StallD=1`, `FlushE=1`.

**Other rules**
- `PCSrcE` and `lwStall` cannot legally coincide. If both are asserted, `PCSrcE` wins.
- Counters increment only outside reset and saturate; they never wrap.

## Timing

**Combinational paths (same cycle as inputs)**
- Stalls, flushes and forwards are Mealy outputs, combinational from their inputs and the current state.
- A load-use hazard costs exactly one bubble: `lwStall` is high for one cycle, then the load is in Memory and `ForwardAE`/`ForwardBE` = `10`.
- A taken branch costs two flushed slots, with `FlushD` and `FlushE` in the same cycle.
- A memory access with N wait cycles (N < `WAIT_TIMEOUT`) holds F/D/E/M for exactly N cycles, with N bubbles into Writeback. The stall drops in the cycle `MemReadyM` rises.

**Registered state (updated at the clock edge)**
- State, wait counter, `MemErr` and both counters are registered. The count for a cycle is visible on the next edge.

**Reset**
- Reset values: state RUN, wait counter 0, `MemErr=0`, `StallCount=0`, `FlushCount=0`.
- `rst` asserted mid-wait or in HALT returns to RUN on the next edge and clears `MemErr`.

## Test plan

- **Load-use bubble:** `lw x5` in Execute (`ResultSrcE=01`, `RdE=5`), `Rs1D=5` → one cycle of `StallF=StallD=FlushE=1`. Next cycle, with `RdM=5` and `RegWriteM=1`, `ForwardAE=10`. `StallCount` increments by 1.
- **Forward priority and x0:**
  - `RdM=RdW=Rs2E=7`, both writes enabled → `ForwardBE=10`.
  - `RdM=0`, `Rs1E=0` → `ForwardAE=00`.
- **Taken branch:** `PCSrcE=1` → `FlushD=FlushE=1`, `StallF=0`. `FlushCount` becomes 1 on the next edge.
- **Memory wait:**
  - `MemReqM=1`, `MemReadyM` low for 3 cycles → 3 cycles with all stalls and `FlushW` = 1, state WAIT. `PCSrcE=1` during the wait produces no flush.
  - After release → RUN. `StallCount` increases by 3.
- **Timeout halt:** `WAIT_TIMEOUT=4`, `MemReadyM` held low → `MemErr=1` after the 4th wait cycle. Stalls stay high thereafter, even if `MemReadyM` later rises. `rst` for one cycle → RUN, `MemErr=0`, counters 0.
- **Reset priority and saturation:**
  - `rst=1` with `lwStall` and `memWait` both active → only `FlushD`/`FlushE`/`FlushW` = 1.
  - `StallCount` forced to `32'hFFFFFFFE`, then 3 stall cycles → holds at `32'hFFFFFFFF`.
